// File: rtl/cpu_frontend_pkg.sv
// Shared frontend definitions: fetch FSM states, kseg translation constants
// and the boot vector.
package cpu_frontend_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_WAIT_DS
    } fetch_state_e;

    // vaddr[31:30] value that selects kseg0/kseg1, and the value forced onto vaddr[31:29]
    localparam logic [1:0] KSEG_SEG_MATCH = 2'b10;
    localparam logic [2:0] KSEG_CLEAR     = 3'b000;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/kseg_xlate.sv
// Combinational unmapped-segment translation (kseg0/kseg1 -> low physical).
// Shared by the ICache and DCache address paths.
module kseg_xlate
    import cpu_frontend_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned KSEG_MAP = 1
) (
    input  logic [ADDR_W-1:0] vaddr,
    output logic [ADDR_W-1:0] paddr
);

    generate
        if (KSEG_MAP != 0 && ADDR_W >= 32) begin : g_map
            always_comb begin
                paddr = vaddr;
                if (vaddr[31:30] == KSEG_SEG_MATCH) begin
                    paddr[31:29] = KSEG_CLEAR;
                end
            end
        end else begin : g_flat
            assign paddr = vaddr;
        end
    endgenerate

endmodule

// File: rtl/fetch_addr_gen.sv
// Fetch PC register and next-PC selection (exception, flush, BPU, sequential)
// with a one-entry buffer for predictions whose delay slot lies in the next group.
module fetch_addr_gen
    import cpu_frontend_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       FETCH_N  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int unsigned       KSEG_MAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_target,
    input  logic              br_flush,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              bpu_taken,
    input  logic              bpu_dely,
    input  logic [ADDR_W-1:0] bpu_target,
    input  logic              stall,
    output logic              icache_req,
    input  logic              icache_addr_ok,
    output logic [ADDR_W-1:0] vaddr_to_icache,
    output logic [ADDR_W-1:0] paddr_to_icache,
    output logic              fetch_fire,
    output logic              pend_valid_o
);

    localparam int unsigned OFF_W = $clog2(4 * FETCH_N);
    localparam int unsigned GRP_W = ADDR_W - OFF_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic [ADDR_W-1:0] seq_pc;

    // Offset bits are dropped, so an unaligned PC still advances to the next group.
    assign seq_pc = {pc_q[ADDR_W-1:OFF_W] + {{(GRP_W-1){1'b0}}, 1'b1}, {OFF_W{1'b0}}};

    assign icache_req      = (state_q != S_BOOT) & ~stall & ~exc_valid & ~br_flush;
    assign fetch_fire      = icache_req & icache_addr_ok;
    assign vaddr_to_icache = pc_q;
    assign pend_valid_o    = pend_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (exc_valid) begin
            pc_d          = exc_target;
            pend_valid_d  = 1'b0;
            pend_target_d = '0;
            state_d       = S_RUN;
        end else if (br_flush) begin
            pc_d          = br_target;
            pend_valid_d  = 1'b0;
            pend_target_d = '0;
            state_d       = S_RUN;
        end else begin
            unique case (state_q)
                S_BOOT: state_d = S_RUN;
                S_RUN: begin
                    if (fetch_fire) begin
                        if (bpu_taken && !bpu_dely) begin
                            pc_d = bpu_target;
                        end else begin
                            pc_d = seq_pc;
                            if (bpu_taken) begin
                                pend_valid_d  = 1'b1;
                                pend_target_d = bpu_target;
                                state_d       = S_WAIT_DS;
                            end
                        end
                    end
                end
                S_WAIT_DS: begin
                    if (fetch_fire) begin
                        pc_d          = pend_target_q;
                        pend_valid_d  = 1'b0;
                        pend_target_d = '0;
                        state_d       = S_RUN;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    kseg_xlate #(
        .ADDR_W   (ADDR_W),
        .KSEG_MAP (KSEG_MAP)
    ) u_xlate (
        .vaddr (pc_q),
        .paddr (paddr_to_icache)
    );

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Bench for fetch_addr_gen: directed vector table plus randomized traffic
// against a PC-level reference model; a second instance is built with KSEG_MAP=0.
module tb_fetch_addr_gen;

    logic        clk = 1'b0;
    logic        rst, exc_valid, br_flush, bpu_taken, bpu_dely, stall, icache_addr_ok;
    logic [31:0] exc_target, br_target, bpu_target;
    logic        req_a, fire_a, pend_a, req_b, fire_b, pend_b;
    logic [31:0] va_a, pa_a, va_b, pa_b;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    fetch_addr_gen #(.ADDR_W(32), .FETCH_N(2), .RESET_PC(32'hBFC0_0000), .KSEG_MAP(1)) dut_a (
        .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_target(exc_target),
        .br_flush(br_flush), .br_target(br_target), .bpu_taken(bpu_taken),
        .bpu_dely(bpu_dely), .bpu_target(bpu_target), .stall(stall),
        .icache_req(req_a), .icache_addr_ok(icache_addr_ok), .vaddr_to_icache(va_a),
        .paddr_to_icache(pa_a), .fetch_fire(fire_a), .pend_valid_o(pend_a));

    fetch_addr_gen #(.ADDR_W(32), .FETCH_N(2), .RESET_PC(32'hBFC0_0000), .KSEG_MAP(0)) dut_b (
        .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_target(exc_target),
        .br_flush(br_flush), .br_target(br_target), .bpu_taken(bpu_taken),
        .bpu_dely(bpu_dely), .bpu_target(bpu_target), .stall(stall),
        .icache_req(req_b), .icache_addr_ok(icache_addr_ok), .vaddr_to_icache(va_b),
        .paddr_to_icache(pa_b), .fetch_fire(fire_b), .pend_valid_o(pend_b));

    // Reference model: the PC as a number, a boot flag and a pending-target slot.
    bit          m_known = 1'b0;
    bit          m_boot;
    bit          m_pend;
    logic [31:0] m_pc, m_pend_t;

    function automatic logic [31:0] xlate(input logic [31:0] a, input bit mapped);
        if (mapped && a >= 32'h8000_0000 && a < 32'hC000_0000) return a & 32'h1FFF_FFFF;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        logic m_req;
        @(negedge clk);
        if (m_known) begin
            m_req = !m_boot && !stall && !exc_valid && !br_flush;
            chk("model_req_a",  {31'd0, req_a}, {31'd0, m_req});
            chk("model_fire_a", {31'd0, fire_a}, {31'd0, m_req && icache_addr_ok});
            chk("model_vaddr_a", va_a, m_pc);
            chk("model_paddr_a", pa_a, xlate(m_pc, 1'b1));
            chk("model_pend_a", {31'd0, pend_a}, {31'd0, m_pend});
            chk("model_vaddr_b", va_b, m_pc);
            chk("model_paddr_b", pa_b, xlate(m_pc, 1'b0));
            chk("model_pend_b", {31'd0, pend_b}, {31'd0, m_pend});
        end
    endtask

    task automatic advance();
        bit fire;
        @(posedge clk);
        fire = !m_boot && !stall && !exc_valid && !br_flush && icache_addr_ok;
        if (rst) begin
            m_pc = 32'hBFC0_0000; m_boot = 1'b1; m_pend = 1'b0; m_known = 1'b1;
        end else if (exc_valid) begin
            m_pc = exc_target; m_pend = 1'b0; m_boot = 1'b0;
        end else if (br_flush) begin
            m_pc = br_target; m_pend = 1'b0; m_boot = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (fire) begin
            if (m_pend) begin
                m_pc = m_pend_t; m_pend = 1'b0;
            end else if (bpu_taken && !bpu_dely) begin
                m_pc = bpu_target;
            end else begin
                if (bpu_taken) begin
                    m_pend = 1'b1; m_pend_t = bpu_target;
                end
                m_pc = (m_pc & 32'hFFFF_FFF8) + 32'd8;
            end
        end
        #1;
    endtask

    typedef struct {
        logic rst, exc; logic [31:0] exc_t;
        logic fl;       logic [31:0] br_t;
        logic tk, dl;   logic [31:0] bp_t;
        logic st, ok;
        logic req;      logic [31:0] va, pa; logic pend;
    } vec_t;

    function automatic vec_t v(input logic r, e, input logic [31:0] et, input logic f,
                               input logic [31:0] bt, input logic tk, dl,
                               input logic [31:0] pt, input logic st, ok, rq,
                               input logic [31:0] va, pa, input logic pd);
        vec_t x;
        x.rst = r; x.exc = e; x.exc_t = et; x.fl = f; x.br_t = bt; x.tk = tk; x.dl = dl;
        x.bp_t = pt; x.st = st; x.ok = ok; x.req = rq; x.va = va; x.pa = pa; x.pend = pd;
        return x;
    endfunction

    task automatic apply(input vec_t x);
        rst = x.rst; exc_valid = x.exc; exc_target = x.exc_t; br_flush = x.fl;
        br_target = x.br_t; bpu_taken = x.tk; bpu_dely = x.dl; bpu_target = x.bp_t;
        stall = x.st; icache_addr_ok = x.ok;
    endtask

    vec_t vt[29];

    initial begin
        //            rst exc exc_t         fl br_t          tk dl bp_t          st ok  req vaddr         paddr(kseg)  pend
        vt[0]  = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 1,  0, 32'hBFC00000, 32'h1FC00000, 0);
        vt[1]  = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 1,  1, 32'hBFC00000, 32'h1FC00000, 0);
        vt[2]  = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 1,  1, 32'hBFC00008, 32'h1FC00008, 0);
        vt[3]  = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 0,  1, 32'hBFC00010, 32'h1FC00010, 0);
        vt[4]  = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 0,  1, 32'hBFC00010, 32'h1FC00010, 0);
        vt[5]  = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 0,  1, 32'hBFC00010, 32'h1FC00010, 0);
        vt[6]  = v(0, 0, 0,            0, 0,            1, 0, 32'hBFC00100, 0, 1,  1, 32'hBFC00010, 32'h1FC00010, 0);
        vt[7]  = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 1,  1, 32'hBFC00100, 32'h1FC00100, 0);
        vt[8]  = v(0, 0, 0,            1, 32'hBFC00018, 0, 0, 0,            0, 1,  0, 32'hBFC00108, 32'h1FC00108, 0);
        vt[9]  = v(0, 0, 0,            0, 0,            1, 1, 32'h80001000, 0, 1,  1, 32'hBFC00018, 32'h1FC00018, 0);
        vt[10] = v(0, 0, 0,            0, 0,            1, 0, 32'h12345678, 0, 0,  1, 32'hBFC00020, 32'h1FC00020, 1);
        vt[11] = v(0, 0, 0,            0, 0,            1, 0, 32'h12345678, 0, 1,  1, 32'hBFC00020, 32'h1FC00020, 1);
        vt[12] = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 1,  1, 32'h80001000, 32'h00001000, 0);
        vt[13] = v(0, 0, 0,            0, 0,            1, 1, 32'h80003000, 0, 1,  1, 32'h80001008, 32'h00001008, 0);
        vt[14] = v(0, 1, 32'hBFC00380, 1, 32'h80002000, 0, 0, 0,            0, 1,  0, 32'h80001010, 32'h00001010, 1);
        vt[15] = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 1,  1, 32'hBFC00380, 32'h1FC00380, 0);
        vt[16] = v(0, 0, 0,            0, 0,            0, 0, 0,            1, 1,  0, 32'hBFC00388, 32'h1FC00388, 0);
        vt[17] = v(0, 1, 32'hFFFFFFF8, 0, 0,            0, 0, 0,            0, 1,  0, 32'hBFC00388, 32'h1FC00388, 0);
        vt[18] = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 1,  1, 32'hFFFFFFF8, 32'hFFFFFFF8, 0);
        vt[19] = v(0, 0, 0,            0, 0,            0, 0, 0,            1, 1,  0, 32'h00000000, 32'h00000000, 0);
        vt[20] = v(0, 1, 32'hA0000000, 0, 0,            0, 0, 0,            0, 1,  0, 32'h00000000, 32'h00000000, 0);
        vt[21] = v(0, 0, 0,            0, 0,            0, 0, 0,            1, 0,  0, 32'hA0000000, 32'h00000000, 0);
        vt[22] = v(0, 1, 32'h80000006, 0, 0,            0, 0, 0,            0, 0,  0, 32'hA0000000, 32'h00000000, 0);
        vt[23] = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 1,  1, 32'h80000006, 32'h00000006, 0);
        vt[24] = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 0,  1, 32'h80000008, 32'h00000008, 0);
        vt[25] = v(0, 0, 0,            0, 0,            1, 1, 32'h90000000, 0, 1,  1, 32'h80000008, 32'h00000008, 0);
        vt[26] = v(1, 1, 32'h11111110, 0, 0,            0, 0, 0,            0, 1,  0, 32'h80000010, 32'h00000010, 1);
        vt[27] = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 1,  0, 32'hBFC00000, 32'h1FC00000, 0);
        vt[28] = v(0, 0, 0,            0, 0,            0, 0, 0,            0, 1,  1, 32'hBFC00000, 32'h1FC00000, 0);

        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        advance();
        advance();

        for (int i = 0; i < 29; i++) begin
            apply(vt[i]);
            settle();
            chk($sformatf("vec%0d_req", i),   {31'd0, req_a}, {31'd0, vt[i].req});
            chk($sformatf("vec%0d_fire", i),  {31'd0, fire_a}, {31'd0, vt[i].req & vt[i].ok});
            chk($sformatf("vec%0d_vaddr", i), va_a, vt[i].va);
            chk($sformatf("vec%0d_paddr", i), pa_a, vt[i].pa);
            chk($sformatf("vec%0d_pend", i),  {31'd0, pend_a}, {31'd0, vt[i].pend});
            chk($sformatf("vec%0d_paddr_flat", i), pa_b, vt[i].va);
            advance();
        end

        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 199) == 0);
            exc_valid      = ($urandom_range(0, 15) == 0);
            br_flush       = ($urandom_range(0, 15) == 0);
            bpu_taken      = ($urandom_range(0, 3) == 0);
            bpu_dely       = $urandom_range(0, 1) == 1;
            stall          = ($urandom_range(0, 3) == 0);
            icache_addr_ok = $urandom_range(0, 1) == 1;
            exc_target     = $urandom;
            br_target      = ($urandom_range(0, 1) == 1) ? {3'b100, 29'($urandom)} : 32'($urandom);
            bpu_target     = $urandom;
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
